// File: rtl/rv32i_data_ram.sv
// Data RAM responder for the RV32I MEM stage: one-entry posted write buffer with
// read forwarding, plus an MMIO window holding the LED register and two counters.
module rv32i_data_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = 10,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_ce_i,
    input  logic        ram_we_i,
    input  logic [31:0] ram_addr_i,
    input  logic [31:0] ram_data_i,
    input  logic [3:0]  ram_mode_i,
    output logic [31:0] ram_data_o,
    output logic        err_o,
    output logic [31:0] led_o
);

    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] idx;
    logic             mmio_hit;
    logic             misaligned;
    logic             mask_ok;
    logic             wr_ok;
    logic             rd_act;

    logic             pend_v_q, pend_v_d;
    logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
    logic [31:0]      pend_data_q, pend_data_d;
    logic [3:0]       pend_be_q, pend_be_d;

    logic [31:0] led_q, led_d;
    logic [31:0] cyc_q, cyc_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        err_q, err_d;

    logic [31:0] fwd_word;
    logic [31:0] mmio_word;

    assign idx        = ram_addr_i[IDX_W+1:2];
    assign mmio_hit   = (ram_addr_i[31:8] == MMIO_BASE[31:8]);
    assign misaligned = (ram_addr_i[1:0] != 2'b00);
    assign wr_ok      = ram_we_i && mask_ok && !misaligned;
    assign rd_act     = ram_ce_i && !ram_we_i;

    always_comb begin
        case (ram_mode_i)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: mask_ok = 1'b1;
            default:                   mask_ok = 1'b0;
        endcase
    end

    // Next-state: posted write capture, LED update, counters and error pulse.
    always_comb begin
        pend_v_d    = wr_ok && !mmio_hit;
        pend_idx_d  = pend_idx_q;
        pend_data_d = pend_data_q;
        pend_be_d   = pend_be_q;
        led_d       = led_q;
        cyc_d       = cyc_q + 32'd1;
        err_d       = ram_we_i ? !wr_ok : (ram_ce_i && misaligned);
        err_cnt_d   = err_cnt_q;

        if (pend_v_d) begin
            pend_idx_d  = idx;
            pend_data_d = ram_data_i;
            pend_be_d   = ram_mode_i;
        end

        if (wr_ok && mmio_hit && ram_addr_i[7:2] == 6'd0) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_mode_i[b]) led_d[8*b +: 8] = ram_data_i[8*b +: 8];
            end
        end

        if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v_q  <= 1'b0;
            led_q     <= 32'd0;
            cyc_q     <= 32'd0;
            err_cnt_q <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            pend_v_q  <= pend_v_d;
            led_q     <= led_d;
            cyc_q     <= cyc_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_idx_q  <= pend_idx_d;
        pend_data_q <= pend_data_d;
        pend_be_q   <= pend_be_d;
    end

    // A reset edge discards the pending entry instead of committing it.
    always_ff @(posedge clk) begin
        if (!rst && pend_v_q) begin
            for (int b = 0; b < 4; b++) begin
                if (pend_be_q[b]) mem[pend_idx_q][8*b +: 8] <= pend_data_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        fwd_word = mem[idx];
        if (pend_v_q && pend_idx_q == idx) begin
            for (int b = 0; b < 4; b++) begin
                if (pend_be_q[b]) fwd_word[8*b +: 8] = pend_data_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        case (ram_addr_i[7:2])
            6'd0:    mmio_word = led_q;
            6'd1:    mmio_word = cyc_q;
            6'd2:    mmio_word = {24'd0, err_cnt_q};
            default: mmio_word = 32'd0;
        endcase
    end

    always_comb begin
        ram_data_o = 32'd0;
        if (!rst && rd_act) ram_data_o = mmio_hit ? mmio_word : fwd_word;
    end

    assign err_o = err_q;
    assign led_o = led_q;

endmodule

// File: tb/tb_rv32i_data_ram.sv
// Bench for rv32i_data_ram: directed scenarios plus random traffic checked against a
// word-level memory model where every accepted write is visible immediately.
module tb_rv32i_data_ram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  mode = 4'd0;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] led;

    always #5 clk = ~clk;

    rv32i_data_ram dut (
        .clk        (clk),
        .rst        (rst),
        .ram_ce_i   (ce),
        .ram_we_i   (we),
        .ram_addr_i (addr),
        .ram_data_i (wdata),
        .ram_mode_i (mode),
        .ram_data_o (rdata),
        .err_o      (err),
        .led_o      (led)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state.
    logic [31:0] mem_m [int];
    logic [31:0] led_m = 32'd0;
    logic [31:0] cyc_m = 32'd0;
    int          errc_m = 0;
    bit          undo_v = 1'b0;
    bit          undo_existed;
    int          undo_key;
    logic [31:0] undo_old;
    logic [31:0] rd_last;

    function automatic bit is_legal(input logic [3:0] m);
        return m inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic bit is_mmio(input logic [31:0] a);
        return a[31:8] == 24'hFFFFFF;
    endfunction

    function automatic logic [31:0] model_read(input logic c, input logic w,
                                               input logic [31:0] a);
        int key = int'(a[11:2]);
        if (!c || w) return 32'd0;
        if (is_mmio(a)) begin
            if (a[7:2] == 6'd0) return led_m;
            if (a[7:2] == 6'd1) return cyc_m;
            if (a[7:2] == 6'd2) return 32'(errc_m);
            return 32'd0;
        end
        return mem_m.exists(key) ? mem_m[key] : 32'hxxxx_xxxx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input logic c, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m, input bit check_rd,
                        input string tag);
        logic exp_err;
        int   key;
        ce = c; we = w; addr = a; wdata = d; mode = m;
        @(negedge clk);
        rd_last = rdata;
        if (check_rd) chk(tag, rdata, model_read(c, w, a));
        exp_err = w ? !(is_legal(m) && a[1:0] == 2'b00) : (c && a[1:0] != 2'b00);
        @(posedge clk);
        #1;
        cyc_m++;
        if (exp_err && errc_m < 255) errc_m++;
        undo_v = 1'b0;
        if (w && !exp_err) begin
            if (is_mmio(a)) begin
                if (a[7:2] == 6'd0) led_m = merge(led_m, d, m);
            end else begin
                key          = int'(a[11:2]);
                undo_v       = 1'b1;
                undo_key     = key;
                undo_existed = mem_m.exists(key);
                undo_old     = undo_existed ? mem_m[key] : 32'd0;
                mem_m[key]   = merge(undo_old, d, m);
            end
        end
        chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        step(1'b1, 1'b1, a, d, m, 1'b1, "wr_rdata");
    endtask

    task automatic rd(input logic [31:0] a, input string tag);
        step(1'b1, 1'b0, a, 32'd0, 4'd0, 1'b1, tag);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, "idle");
    endtask

    // A reset edge drops any write captured on the edge before it and any write driven now.
    task automatic rst_step(input logic w, input logic [31:0] a, input logic [31:0] d);
        rst = 1'b1; ce = 1'b1; we = w; addr = a; wdata = d; mode = 4'hF;
        @(negedge clk);
        chk("rst_rdata", rdata, 32'd0);
        @(posedge clk);
        #1;
        if (undo_v) begin
            if (undo_existed) mem_m[undo_key] = undo_old;
            else mem_m.delete(undo_key);
        end
        undo_v = 1'b0;
        led_m  = 32'd0;
        cyc_m  = 32'd0;
        errc_m = 0;
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_led", led, 32'd0);
        rst = 1'b0;
    endtask

    logic [3:0] legal_tab [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

    initial begin
        logic [3:0]  m;
        logic [31:0] a;
        int          r;

        rst_step(1'b0, 32'h10, 32'd0);
        rst_step(1'b0, 32'h10, 32'd0);
        rd(32'hFFFF_FF04, "cyc_after_reset");
        rd(32'hFFFF_FF08, "errcnt_after_reset");

        // Forwarded read, then array read of a full-word store.
        wr(32'h10, 32'hDEADBEEF, 4'hF);
        rd(32'h10, "fwd_full");
        chk("fwd_full_const", rd_last, 32'hDEADBEEF);
        idle();
        rd(32'h10, "array_full");
        chk("array_full_const", rd_last, 32'hDEADBEEF);

        // Partial store merges pending lane over array contents.
        wr(32'h20, 32'h11223344, 4'hF);
        idle();
        wr(32'h20, 32'hAAAAAAAA, 4'b0100);
        rd(32'h20, "fwd_partial");
        chk("fwd_partial_const", rd_last, 32'h11AA3344);
        idle();
        rd(32'h20, "array_partial");
        chk("array_partial_const", rd_last, 32'h11AA3344);

        // Back-to-back stores.
        wr(32'h30, 32'h1, 4'hF);
        wr(32'h34, 32'h2, 4'hF);
        rd(32'h30, "b2b_first");
        chk("b2b_first_const", rd_last, 32'h1);
        rd(32'h34, "b2b_second");
        chk("b2b_second_const", rd_last, 32'h2);

        // Rejected accesses.
        wr(32'h20, 32'h55555555, 4'b0101);
        rd(32'h20, "illegal_mask_nochange");
        chk("illegal_mask_const", rd_last, 32'h11AA3344);
        rd(32'hFFFF_FF08, "errcnt_one");
        chk("errcnt_one_const", rd_last, 32'h1);
        rd(32'h22, "misaligned_read");
        chk("misaligned_read_const", rd_last, 32'h11AA3344);
        wr(32'h36, 32'h99999999, 4'hF);
        rd(32'h34, "misaligned_wr_nochange");
        step(1'b0, 1'b0, 32'h10, 32'd0, 4'd0, 1'b1, "ce_low_zero");

        // MMIO window and aliasing.
        wr(32'hF00, 32'hCAFEF00D, 4'hF);
        idle();
        wr(32'hFFFF_FF00, 32'h0000_00FF, 4'b0001);
        chk("led_lane0", led, 32'h0000_00FF);
        wr(32'hFFFF_FF00, 32'hABABABAB, 4'b0010);
        chk("led_lane1", led, 32'h0000_ABFF);
        rd(32'hFFFF_FF04, "cycle_cnt");
        rd(32'hFFFF_FF00, "led_read");
        rd(32'hF00, "alias_unchanged");
        chk("alias_const", rd_last, 32'hCAFEF00D);
        wr(32'hFFFF_FF10, 32'h12345678, 4'hF);
        rd(32'hFFFF_FF10, "mmio_other_zero");

        // Random traffic over a small preloaded region.
        for (int i = 0; i < 16; i++) wr(32'h100 + 32'(4 * i), $urandom, 4'hF);
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 10);
            a = 32'h100 + 32'(4 * $urandom_range(0, 15));
            if (r <= 4) begin
                wr(a, $urandom, legal_tab[$urandom_range(0, 6)]);
            end else if (r <= 8) begin
                rd(a, "rand_read");
            end else if (r == 9) begin
                do m = 4'($urandom_range(0, 15)); while (is_legal(m));
                wr(a, $urandom, m);
            end else begin
                rd(32'hFFFF_FF08, "rand_errcnt");
            end
        end

        // Error counter saturation.
        for (int i = 0; i < 260; i++) wr(32'h24, 32'h0, 4'b0101);
        rd(32'hFFFF_FF08, "errcnt_sat");
        chk("errcnt_sat_const", rd_last, 32'hFF);

        // Reset discards a pending write and a write coinciding with reset.
        wr(32'h40, 32'h12345678, 4'hF);
        idle();
        wr(32'h40, 32'h5, 4'hF);
        rst_step(1'b1, 32'h40, 32'h77777777);
        rd(32'hFFFF_FF04, "cyc_restart");
        chk("cyc_restart_const", rd_last, 32'h0);
        rd(32'h40, "reset_discard");
        chk("reset_discard_const", rd_last, 32'h12345678);
        chk("led_after_reset", led, 32'h0);
        rd(32'hFFFF_FF08, "errcnt_cleared");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rv32i_data_ram.md
Name: rv32i_data_ram

Overview:
Data-memory responder on the RV32I pipeline's data RAM port. It accepts chip-enable, write-enable, word-aligned address, replicated write data and a 4-bit byte-lane mask from the MEM stage. It returns a full 32-bit word combinationally in the same cycle for loads; the MEM stage performs lane extraction and sign extension. Stores are posted through a one-entry write buffer with read forwarding. A small MMIO window carries an LED register, a cycle counter and an error counter.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two).
IDX_W, 10, log2(DEPTH_WORDS).
MMIO_BASE, 32'hFFFF_FF00, base of the 256-byte MMIO window; matched on addr[31:8].

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset; synchronous, active-high
ram_ce_i  in  1  read enable, active-high
ram_we_i  in  1  write enable, active-high; has priority over ram_ce_i
ram_addr_i  in  32  byte address; the MEM stage supplies it word-aligned
ram_data_i  in  32  write data, already lane-replicated by the MEM stage
ram_mode_i  in  4  byte-lane enables; bit n = byte lane n
ram_data_o  out  32  read data, combinational
err_o  out  1  one-cycle registered pulse when an access is rejected
led_o  out  32  MMIO LED register

Behaviour:
- Word index: idx = ram_addr_i[IDX_W+1:2]. Upper bits outside the MMIO window are ignored, so the array aliases modulo DEPTH_WORDS*4.
- MMIO hit: ram_addr_i[31:8] == MMIO_BASE[31:8]. Offsets use addr[7:0].
- Legal write masks: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- Write rejected when ram_we_i=1 and either the mask is illegal or addr[1:0]!=0:
  - Nothing is written.
  - err_o=1 in the next cycle.
  - The error counter increments.
- Read with addr[1:0]!=0: data is returned from the word-aligned index; err_o pulses; the counter increments.
- Array write (posted):
  - At a clock edge with ram_we_i=1, an accepted write and no MMIO hit, capture pend_v=1, pend_idx, pend_data, pend_be.
  - At every edge where pend_v=1, commit pend_data to array[pend_idx] in lanes where pend_be=1.
  - Back-to-back writes: commit the old entry and capture the new one in the same edge.
  - pend_v clears when no new write is captured.
- Array read: when ram_ce_i=1, ram_we_i=0 and no MMIO hit, ram_data_o = array[idx].
  - Each lane n is replaced by pend_data lane n if pend_v, pend_idx==idx and pend_be[n].
  - Combinational, zero latency.
- ram_data_o=0 when ram_ce_i=0, when ram_we_i=1, or during rst.
- MMIO writes are applied at the edge, not posted; they never touch the array or the pending entry.
  - Offset 0x00: led_o is updated lane-wise per ram_mode_i.
  - Other offsets: write ignored, no error.
- MMIO reads:
  - 0x00 returns led_o.
  - 0x04 returns cycle_cnt.
  - 0x08 returns {24'b0, err_cnt}.
  - Other offsets return 0.
- cycle_cnt: 32-bit, increments every non-reset cycle, wraps 32'hFFFF_FFFF -> 0.
- err_cnt: 8-bit, saturates at 255.
- Reset values: pend_v=0, led_o=0, cycle_cnt=0, err_cnt=0, err_o=0. Array contents are not reset.
- Reset while pend_v=1: the pending write is discarded and not committed.
- A write that coincides with rst is dropped.

Test Plan:
- Write 32'hDEADBEEF to 0x10, mask 1111; next cycle read 0x10 (forwarded path) -> 32'hDEADBEEF. Read again two cycles later (array path) -> same value.
- Preload 0x20 with 32'h11223344; write data 32'hAAAAAAAA with mask 0100; read immediately -> 32'h11AA3344. Read after commit -> same value.
- Back-to-back writes 0x30 <- 32'h1, then 0x34 <- 32'h2, then read both -> 32'h1 and 32'h2, no lost commit.
- Write with mask 0101 -> no array change, err_o=1 one cycle later. MMIO read 0xFFFF_FF08 -> 32'h1.
- Write 0xFFFF_FF00 with data 32'h0000_00FF, mask 0001 -> led_o=32'h0000_00FF. Read 0xFFFF_FF04 -> cycle count since reset. Array word at the aliased index is unchanged.
- Write 0x40 <- 32'h5 with rst asserted in the following cycle -> pending write discarded; read 0x40 after reset -> prior contents; led_o=0, cycle_cnt restarts at 0.
